weighted_rr_arbiter: RTL and testbench

- N-requester weighted round-robin arbiter with a credit counter per grant and a downstream ready handshake.
- Parametrised successor to the plain round-robin arbiter. Each requester may hold the grant for up to weight[i] accepted beats before priority rotates.
- Sits between N source queues and one shared downstream port (bus master mux, memory port).
- Grant is registered, one-hot, and switches back-to-back without a bubble.

---
 rtl/weighted_rr_arbiter.sv | 107 ++++++++++
 tb/tb_weighted_rr_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: N requesters share one port; each grant lasts up to weight[i] accepted beats.
// Latency: 1 cycle req->grant, back-to-back regrant without a bubble. Backpressure: ready=0 stalls and never consumes credit.
// Optional atomic-sequence lock input enabled by defining WRR_ARB_LOCK_EN.
module weighted_rr_arbiter #(
    parameter  int N  = 4,
    parameter  int WW = 4,
    localparam int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
    input  logic            ready,
`ifdef WRR_ARB_LOCK_EN
    input  logic            lock,
`endif
    output logic [N-1:0]    grant,
    output logic            grant_vld,
    output logic [IW-1:0]   grant_id,
    output logic [WW-1:0]   credit
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_GRANTED = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_grant;
    logic            r_grant_vld;
    logic [IW-1:0]   r_grant_id;
    logic [WW-1:0]   r_credit;
    logic [IW-1:0]   r_ptr;

    logic [WW-1:0]   w_wt [N];
    logic [IW-1:0]   w_win;
    logic            w_any;
    logic [WW-1:0]   w_ew;
    logic            w_cur_req;
    logic            w_beat;
    logic            w_lock;
    logic            w_release;
    logic            w_rearb;

`ifdef WRR_ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    for (genvar g = 0; g < N; g++) begin : g_wt
        assign w_wt[g] = weight[g*WW +: WW];
    end

    // Scan from the farthest offset down so the nearest requester after r_ptr wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(r_ptr) + k) % N]) begin
                w_any = 1'b1;
                w_win = IW'((int'(r_ptr) + k) % N);
            end
        end
    end

    assign w_ew      = (w_wt[w_win] == '0) ? WW'(1) : w_wt[w_win];
    assign w_cur_req = req[r_grant_id];
    assign w_beat    = (r_state == S_GRANTED) && ready && w_cur_req;
    assign w_release = (r_state == S_GRANTED) &&
                       (!w_cur_req || (w_beat && !w_lock && (r_credit == WW'(1))));
    assign w_rearb   = (r_state == S_IDLE) || w_release;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_grant_vld <= 1'b0;
            r_grant_id  <= '0;
            r_credit    <= '0;
            r_ptr       <= IW'(N - 1);
        end else if (w_rearb) begin
            if (w_any) begin
                r_state     <= S_GRANTED;
                r_grant     <= {{(N-1){1'b0}}, 1'b1} << w_win;
                r_grant_vld <= 1'b1;
                r_grant_id  <= w_win;
                r_credit    <= w_ew;
                r_ptr       <= w_win;
            end else begin
                // grant_id deliberately keeps the last holder while idle
                r_state     <= S_IDLE;
                r_grant     <= '0;
                r_grant_vld <= 1'b0;
                r_credit    <= '0;
            end
        end else if (w_beat && !w_lock) begin
            r_credit <= r_credit - WW'(1);
        end
    end

    assign grant     = r_grant;
    assign grant_vld = r_grant_vld;
    assign grant_id  = r_grant_id;
    assign credit    = r_credit;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Bench for weighted_rr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_weighted_rr_arbiter;

    localparam int N  = 4;
    localparam int WW = 4;

`ifdef WRR_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [15:0]   weight;
    logic          ready;
    logic          lock;
    logic [N-1:0]  grant;
    logic          grant_vld;
    logic [1:0]    grant_id;
    logic [WW-1:0] credit;

    always #5 clk = ~clk;

    weighted_rr_arbiter #(.N(N), .WW(WW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .weight    (weight),
        .ready     (ready),
`ifdef WRR_ARB_LOCK_EN
        .lock      (lock),
`endif
        .grant     (grant),
        .grant_vld (grant_vld),
        .grant_id  (grant_id),
        .credit    (credit)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Model: owner index (-1 = idle), beats left in the grant, last holder, rotation pointer.
    int m_owner, m_left, m_id, m_ptr;

    function automatic logic [15:0] wpack(input logic [3:0] a, input logic [3:0] b,
                                          input logic [3:0] c, input logic [3:0] d);
        return {d, c, b, a};
    endfunction

    function automatic int eff_w(input int i);
        int w;
        w = int'(weight[i*WW +: WW]);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_left = 0; m_id = 0; m_ptr = N - 1;
    endtask

    task automatic model_arb();
        bit found = 0;
        for (int k = 1; k <= N; k++) begin
            int c = (m_ptr + k) % N;
            if (!found && req[c]) begin
                found = 1; m_owner = c; m_ptr = c; m_id = c; m_left = eff_w(c);
            end
        end
        if (!found) begin
            m_owner = -1; m_left = 0;
        end
    endtask

    task automatic model_edge();
        if (m_owner < 0 || !req[m_owner]) model_arb();
        else if (ready) begin
            if (LOCK_EN && lock) begin
            end else if (m_left == 1) model_arb();
            else m_left--;
        end
    endtask

    task automatic check_model(input string tag);
        logic [N-1:0] eg;
        eg = (m_owner < 0) ? '0 : N'(1 << m_owner);
        chk({tag, "_grant"},  grant,     eg);
        chk({tag, "_vld"},    grant_vld, (m_owner >= 0));
        chk({tag, "_id"},     grant_id,  m_id);
        chk({tag, "_credit"}, credit,    m_left);
    endtask

    task automatic step(input logic [N-1:0] r, input logic rdy, input logic lk, input string tag);
        req = r; ready = rdy; lock = lk;
        model_edge();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic apply_reset(input logic [15:0] w);
        rst_n = 1'b0; req = '0; ready = 1'b0; lock = 1'b0; weight = w;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        chk("rst_grant", grant, 0);
        chk("rst_vld", grant_vld, 0);
        chk("rst_id", grant_id, 0);
        chk("rst_credit", credit, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0] s1_g [9] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    logic [3:0] s2_g [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    logic [3:0] s2_c [8] = '{4'd3, 4'd2, 4'd1, 4'd1, 4'd3, 4'd2, 4'd1, 4'd1};

    initial begin
        // Full rotation with weight 2 everywhere
        apply_reset(wpack(2, 2, 2, 2));
        for (int i = 0; i < 9; i++) begin
            step(4'b1111, 1'b1, 1'b0, "s1");
            chk("s1_seq_grant", grant, s1_g[i]);
            chk("s1_seq_credit", credit, (i % 2 == 0) ? 2 : 1);
        end

        // Zero weight behaves as one
        apply_reset(wpack(3, 0, 5, 5));
        for (int i = 0; i < 8; i++) begin
            step(4'b0011, 1'b1, 1'b0, "s2");
            chk("s2_seq_grant", grant, s2_g[i]);
            chk("s2_seq_credit", credit, s2_c[i]);
        end

        // Stall on requester 2 never consumes credit
        apply_reset(wpack(1, 1, 3, 2));
        step(4'b0100, 1'b0, 1'b0, "s3");
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b0, 1'b0, "s3stall");
            chk("s3_stall_grant", grant, 4'b0100);
            chk("s3_stall_credit", credit, 3);
        end
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0, "s3go");
        chk("s3_rotate", grant, 4'b1000);
        chk("s3_rotate_credit", credit, 2);

        // Holder drops req while requester 3 waits
        apply_reset(wpack(1, 4, 1, 3));
        step(4'b0010, 1'b1, 1'b0, "s4");
        chk("s4_credit4", credit, 4);
        step(4'b1010, 1'b1, 1'b0, "s4");
        step(4'b1000, 1'b1, 1'b0, "s4");
        chk("s4_handoff", grant, 4'b1000);
        chk("s4_handoff_credit", credit, 3);

        // Holder drops req with nobody else pending
        apply_reset(wpack(1, 4, 1, 3));
        step(4'b0010, 1'b1, 1'b0, "s4b");
        step(4'b0010, 1'b1, 1'b0, "s4b");
        step(4'b0000, 1'b1, 1'b0, "s4b");
        chk("s4b_idle_grant", grant, 0);
        chk("s4b_idle_credit", credit, 0);
        chk("s4b_idle_id", grant_id, 1);

        // Lone requester is regranted back to back
        apply_reset(wpack(2, 1, 1, 1));
        for (int i = 0; i < 6; i++) begin
            step(4'b0001, 1'b1, 1'b0, "s5");
            chk("s5_grant", grant, 4'b0001);
            chk("s5_credit", credit, (i % 2 == 0) ? 2 : 1);
        end

        // Asynchronous reset mid-burst
        apply_reset(wpack(2, 2, 2, 2));
        step(4'b1111, 1'b1, 1'b0, "s6");
        #3;
        rst_n = 1'b0;
        #1;
        chk("s6_async_grant", grant, 0);
        chk("s6_async_vld", grant_vld, 0);
        chk("s6_async_credit", credit, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, 1'b1, 1'b0, "s6");
        chk("s6_first_grant", grant, 4'b0001);

`ifdef WRR_ARB_LOCK_EN
        // Locked beats hold a weight-1 grant
        apply_reset(wpack(1, 1, 1, 1));
        step(4'b0011, 1'b1, 1'b0, "s7");
        for (int i = 0; i < 4; i++) begin
            step(4'b0011, 1'b1, 1'b1, "s7lock");
            chk("s7_lock_grant", grant, 4'b0001);
            chk("s7_lock_credit", credit, 1);
        end
        step(4'b0011, 1'b1, 1'b0, "s7");
        chk("s7_unlock_rotate", grant, 4'b0010);
`endif

        // Randomized traffic against the model
        apply_reset(wpack(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom)));
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 49) weight = 16'($urandom);
            step(4'($urandom & $urandom_range(0, 15)) | 4'($urandom),
                 ($urandom_range(0, 3) != 0),
                 LOCK_EN && ($urandom_range(0, 3) == 0), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
